// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin two-port arbiter/sequencer, sole master of stack_ctrl's command port.
// Optional WAIT_ACK timeout is compiled in when STACK_ARB_TIMEOUT_EN is defined.

module stack_arbiter_checker #(
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  input logic              stk_push,
  input logic              stk_pop,
  input logic [DATA_W-1:0] stk_din,
  input logic              ack_a,
  input logic              ack_b,
  input logic              err
);

  a_no_dual_strobe: assert property (@(posedge clk) disable iff (!rst_n)
    !(stk_push && stk_pop));

  a_push_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    stk_push |=> !stk_push);

  a_pop_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    stk_pop |=> !stk_pop);

  a_din_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (!stk_push && !stk_pop) |-> (stk_din == '0));

  a_single_ack: assert property (@(posedge clk) disable iff (!rst_n)
    !(ack_a && ack_b));

  a_err_with_ack: assert property (@(posedge clk) disable iff (!rst_n)
    err |-> (ack_a || ack_b));

endmodule

module stack_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              op_a,
  input  logic              op_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  input  logic              stk_pushed,
  input  logic              stk_poped,
  input  logic              stk_full,
  input  logic              stk_empty
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              last_r;
  logic              grant_r;
  logic              grant_nxt_s;
  logic              op_r;
  logic              op_nxt_s;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] wdata_nxt_s;
  logic              err_nxt_s;
  logic              rdata_clr_s;
  logic              rdata_cap_s;
  logic              timeout_s;

  logic              ack_a_r;
  logic              ack_b_r;
  logic              err_r;
  logic [DATA_W-1:0] rdata_r;
  logic              stk_push_r;
  logic              stk_pop_r;
  logic [DATA_W-1:0] stk_din_r;

`ifdef STACK_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_r;

  // WAIT_ACK cycle counter; held at zero outside WAIT_ACK so each entry starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (state_r != ST_WAIT_ACK) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_W'(TIMEOUT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout_s = (state_r == ST_WAIT_ACK) && (cnt_r == CNT_W'(TIMEOUT));
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register plus the latched grant, op and write data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      grant_r <= PORT_B;
      op_r    <= 1'b0;
      wdata_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      op_r    <= op_nxt_s;
      wdata_r <= wdata_nxt_s;
    end
  end

  // Next-state logic: arbitration in IDLE, full/empty rejection, acknowledge tracking
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    op_nxt_s    = op_r;
    wdata_nxt_s = wdata_r;
    err_nxt_s   = 1'b0;
    rdata_clr_s = 1'b0;
    rdata_cap_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_a || req_b) begin
          if (req_a && req_b) begin
            grant_nxt_s = ~last_r;
          end else if (req_a) begin
            grant_nxt_s = PORT_A;
          end else begin
            grant_nxt_s = PORT_B;
          end
          op_nxt_s    = (grant_nxt_s == PORT_B) ? op_b : op_a;
          wdata_nxt_s = (grant_nxt_s == PORT_B) ? wdata_b : wdata_a;
          // Rejected commands never reach stack_ctrl
          if ((op_nxt_s && stk_full) || (!op_nxt_s && stk_empty)) begin
            state_nxt_s = ST_DONE;
            err_nxt_s   = 1'b1;
            rdata_clr_s = 1'b1;
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (op_r && stk_pushed) begin
          state_nxt_s = ST_DONE;
        end else if (!op_r && stk_poped) begin
          state_nxt_s = ST_WAIT_DATA;
        end else if (timeout_s) begin
          state_nxt_s = ST_DONE;
          err_nxt_s   = 1'b1;
          rdata_clr_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DATA: begin
        rdata_cap_s = 1'b1;
        state_nxt_s = ST_DONE;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output registers, loaded from the next state so each pulse lines up with its FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r     <= PORT_B;
      ack_a_r    <= 1'b0;
      ack_b_r    <= 1'b0;
      err_r      <= 1'b0;
      rdata_r    <= '0;
      stk_push_r <= 1'b0;
      stk_pop_r  <= 1'b0;
      stk_din_r  <= '0;
    end else begin
      if (state_r == ST_DONE) begin
        last_r <= grant_r;
      end else begin
        last_r <= last_r;
      end
      ack_a_r    <= (state_nxt_s == ST_DONE) && (grant_nxt_s == PORT_A);
      ack_b_r    <= (state_nxt_s == ST_DONE) && (grant_nxt_s == PORT_B);
      err_r      <= err_nxt_s;
      stk_push_r <= (state_nxt_s == ST_ISSUE) && op_nxt_s;
      stk_pop_r  <= (state_nxt_s == ST_ISSUE) && !op_nxt_s;
      stk_din_r  <= (state_nxt_s == ST_ISSUE) ? wdata_nxt_s : '0;
      if (rdata_clr_s) begin
        rdata_r <= '0;
      end else if (rdata_cap_s) begin
        rdata_r <= stk_dout;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign ack_a    = ack_a_r;
  assign ack_b    = ack_b_r;
  assign err      = err_r;
  assign rdata    = rdata_r;
  assign stk_push = stk_push_r;
  assign stk_pop  = stk_pop_r;
  assign stk_din  = stk_din_r;

  stack_arbiter_checker #(
    .DATA_W (DATA_W)
  ) u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .stk_push (stk_push_r),
    .stk_pop  (stk_pop_r),
    .stk_din  (stk_din_r),
    .ack_a    (ack_a_r),
    .ack_b    (ack_b_r),
    .err      (err_r)
  );

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed, table-driven bench for stack_arbiter against a behavioural 8-entry stack_ctrl stub.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b, op_a, op_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, ack_b, err;
  logic [7:0] rdata;
  logic       stk_push, stk_pop;
  logic [7:0] stk_din, stk_dout;
  logic       stk_pushed, stk_poped, stk_full, stk_empty;

  always #5 clk = ~clk;

  stack_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .err(err), .rdata(rdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
    .stk_pushed(stk_pushed), .stk_poped(stk_poped), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  // stack_ctrl stub: ack one cycle after the strobe, pop data one cycle after the ack
  logic [7:0] mem [0:7];
  logic [3:0] sp;
  logic       rd_pend;
  logic [2:0] rd_addr;
  logic       hold_ack = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 4'd0; stk_pushed <= 1'b0; stk_poped <= 1'b0;
      stk_dout <= 8'h00; rd_pend <= 1'b0; rd_addr <= 3'd0;
    end else begin
      stk_pushed <= 1'b0;
      stk_poped  <= 1'b0;
      rd_pend    <= 1'b0;
      if (stk_push && sp != 4'd8) begin
        mem[sp[2:0]] <= stk_din;
        sp <= sp + 4'd1;
        stk_pushed <= !hold_ack;
      end else if (stk_pop && sp != 4'd0) begin
        sp <= sp - 4'd1;
        stk_poped <= 1'b1;
        rd_pend <= 1'b1;
        rd_addr <= sp[2:0] - 3'd1;
      end
      if (rd_pend) stk_dout <= mem[rd_addr];
    end
  end

  assign stk_full  = (sp == 4'd8);
  assign stk_empty = (sp == 4'd0);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct {
    logic       port;   // 0 = A, 1 = B
    logic       op;     // 1 = push
    logic [7:0] wd;
    int         lat;
    logic       err;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [0:16];

  int         t_lat, t_npush, t_npop;
  logic       t_err, t_bad;
  logic [7:0] t_rd;

  // One transaction from a single port; called just after a negedge with the DUT in IDLE
  task automatic do_txn(input logic port, input logic op, input logic [7:0] wd,
                        output int lat, output logic e, output logic [7:0] rd,
                        output int np, output int npp, output logic bad);
    lat = 0; e = 1'b0; rd = 8'h00; np = 0; npp = 0; bad = 1'b0;
    if (port) begin req_b = 1'b1; op_b = op; wdata_b = wd; end
    else      begin req_a = 1'b1; op_a = op; wdata_a = wd; end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      np  += int'(stk_push);
      npp += int'(stk_pop);
      if (stk_push && stk_pop) bad = 1'b1;
      if ((stk_push || stk_pop) && stk_din !== wd && stk_push) bad = 1'b1;
      if (!stk_push && stk_din !== 8'h00) bad = 1'b1;
      if (port ? ack_a : ack_b) bad = 1'b1;
      if (port ? ack_b : ack_a) begin
        lat = k; e = err; rd = rdata;
        break;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); @(negedge clk);
    if (ack_a || ack_b || err) bad = 1'b1;
  endtask

  int         n_ack;
  logic       ovl;
  int         g_port, g_push;
  logic       din_ok;
  logic [7:0] exp_din;

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; op_a = 1'b0; op_b = 1'b0;
    wdata_a = 8'h00; wdata_b = 8'h00;

    vecs[0]  = '{1'b0, 1'b1, 8'h11, 3, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'h22, 3, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 4, 1'b0, 8'h22};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 4, 1'b0, 8'h11};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1, 1'b1, 8'h00};
    for (int i = 0; i < 8; i++) vecs[5+i] = '{1'b0, 1'b1, 8'(i), 3, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 1'b1, 8'h08, 1, 1'b1, 8'h00};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 4, 1'b0, 8'h07};
    vecs[15] = '{1'b1, 1'b1, 8'h5A, 3, 1'b0, 8'h07};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 4, 1'b0, 8'h5A};

    @(negedge clk); @(negedge clk);
    check("reset_outputs", {ack_a, ack_b, err, stk_push, stk_pop, rdata, stk_din}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {ack_a, ack_b, err, stk_push, stk_pop, rdata, stk_din}, 32'h0);

    for (int i = 0; i <= 16; i++) begin
      do_txn(vecs[i].port, vecs[i].op, vecs[i].wd, t_lat, t_err, t_rd, t_npush, t_npop, t_bad);
      check($sformatf("v%0d_latency", i), t_lat, vecs[i].lat);
      check($sformatf("v%0d_err", i), t_err, vecs[i].err);
      check($sformatf("v%0d_rdata", i), t_rd, vecs[i].rd);
      check($sformatf("v%0d_push_cnt", i), t_npush, (vecs[i].op && !vecs[i].err) ? 1 : 0);
      check($sformatf("v%0d_pop_cnt", i), t_npop, (!vecs[i].op && !vecs[i].err) ? 1 : 0);
      check($sformatf("v%0d_protocol", i), t_bad, 1'b0);
      if (i == 13) check("full_after_9th_push", stk_full, 1'b1);
    end

    // Reset while a pop sits in WAIT_DATA
    req_a = 1'b1; op_a = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); @(negedge clk); end
    check("pre_reset_rdata", rdata, 8'h5A);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {ack_a, ack_b, err, stk_push, stk_pop, rdata, stk_din}, 32'h0);
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      n_ack += int'(ack_a) + int'(ack_b);
    end
    check("no_ack_after_reset", n_ack, 0);

    do_txn(1'b0, 1'b1, 8'h33, t_lat, t_err, t_rd, t_npush, t_npop, t_bad);
    check("post_reset_push_latency", t_lat, 3);
    check("post_reset_push_err", t_err, 1'b0);
    do_txn(1'b1, 1'b0, 8'h00, t_lat, t_err, t_rd, t_npush, t_npop, t_bad);
    check("post_reset_pop_latency", t_lat, 4);
    check("post_reset_pop_rdata", t_rd, 8'h33);

    // Both ports held high: grants must alternate A, B, A, B ...
    req_a = 1'b1; req_b = 1'b1; op_a = 1'b1; op_b = 1'b1;
    wdata_a = 8'hA0; wdata_b = 8'hB0; ovl = 1'b0;
    for (int g = 0; g < 8; g++) begin
      g_port = 9; g_push = 0; din_ok = 1'b1;
      exp_din = (g % 2 == 0) ? 8'(8'hA0 + g / 2) : 8'(8'hB0 + g / 2);
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); @(negedge clk);
        if (stk_push && stk_pop) ovl = 1'b1;
        if (stk_push) begin
          g_push++;
          if (stk_din !== exp_din) din_ok = 1'b0;
        end
        if (ack_a || ack_b) begin
          g_port = (ack_a && ack_b) ? 3 : int'(ack_b);
          if (ack_a) wdata_a = wdata_a + 8'h01;
          if (ack_b) wdata_b = wdata_b + 8'h01;
          break;
        end
      end
      check($sformatf("rr_grant_%0d", g), g_port, g % 2);
      check($sformatf("rr_push_cnt_%0d", g), g_push, 1);
      check($sformatf("rr_din_%0d", g), din_ok, 1'b1);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rr_no_overlap", ovl, 1'b0);
    check("rr_stack_full", stk_full, 1'b1);

`ifdef STACK_ARB_TIMEOUT_EN
    do_txn(1'b1, 1'b0, 8'h00, t_lat, t_err, t_rd, t_npush, t_npop, t_bad);
    check("to_pre_pop_rdata", t_rd, 8'hB3);
    hold_ack = 1'b1;
    do_txn(1'b0, 1'b1, 8'h77, t_lat, t_err, t_rd, t_npush, t_npop, t_bad);
    hold_ack = 1'b0;
    check("timeout_latency", t_lat, 18);
    check("timeout_err", t_err, 1'b1);
    check("timeout_rdata", t_rd, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
